// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - execute-stage ALU with valid/ready handshake and iterative shifter
module alu_seq_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] alu_val;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   amount;
    logic             is_shift;
    logic             accept;

    assign amount   = srcB[SHW-1:0];
    assign is_shift = (operation == 4'b0100) || (operation == 4'b0101) || (operation == 4'b0111);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath; shift-by-zero passes srcA through.
    always_comb begin
        alu_val = '0;
        case (operation)
            4'b0000: alu_val = srcA & srcB;
            4'b0001: alu_val = srcA | srcB;
            4'b0010: alu_val = srcA + srcB;
            4'b0011: alu_val = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            4'b0100: alu_val = srcA;
            4'b0101: alu_val = srcA;
            4'b0110: alu_val = srcA - srcB;
            4'b0111: alu_val = srcA;
            4'b1000: alu_val = {{(WIDTH-1){1'b0}}, (srcA == srcB)};
            4'b1001: alu_val = srcA ^ srcB;
            4'b1100: alu_val = srcA + srcB;
            default: alu_val = '0;
        endcase
    end

    always_comb begin
        shifted = '0;
        case (op_q)
            4'b0100: shifted = {acc_q[WIDTH-2:0], 1'b0};
            4'b0101: shifted = {1'b0, acc_q[WIDTH-1:1]};
            default: shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            op_q     <= op_d;
        end
    end

    // Accept is only possible in IDLE or in DONE with out_ready, so it takes priority over the state case.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        acc_d    = acc_q;
        count_d  = count_q;
        op_d     = op_q;
        if (flush) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (accept) begin
            op_d = operation;
            if (is_shift && (amount != '0)) begin
                acc_d   = srcA;
                count_d = amount;
                state_d = S_LOAD;
            end else begin
                result_d = alu_val;
                state_d  = S_DONE;
            end
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_LOAD:  state_d = S_SHIFT;
                S_SHIFT: begin
                    acc_d   = shifted;
                    count_d = count_q - 1'b1;
                    if (count_q == SHW'(1)) begin
                        result_d = shifted;
                        state_d  = S_DONE;
                    end
                end
                S_DONE:  if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        result    = result_q;
        zero      = (result_q == '0);
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - directed self-checking bench for alu_seq_exec
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  operation = 4'h0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_seq_exec #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .operation(operation),
        .srcA(srcA), .srcB(srcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        operation = op; srcA = a; srcB = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0; srcA = '0; srcB = '0; operation = 4'hf;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;
        total_cnt++; if ({out_valid, busy} !== 2'b00) $display("FAIL reset_flags: valid,busy=%b want 00", {out_valid, busy}); else pass_cnt++;
        total_cnt++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_add();
        operation = 4'b0010; srcA = 32'd5; srcB = 32'd7; in_valid = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL add_ready: got %b want 1", in_ready); else pass_cnt++;
        step();
        in_valid = 1'b0; srcA = '0; srcB = '0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL add_latency: out_valid %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if ({result, zero} !== {32'd12, 1'b0}) $display("FAIL add_result: got %h z=%b want 0000000c z=0", result, zero); else pass_cnt++;
        consume();
        total_cnt++; if ({out_valid, busy} !== 2'b00) $display("FAIL add_consume: valid,busy=%b want 00", {out_valid, busy}); else pass_cnt++;
    endtask

    task automatic test_sub_slt_eq();
        issue(4'b0110, 32'h1234, 32'h1234);
        total_cnt++; if ({out_valid, result, zero} !== {1'b1, 32'h0, 1'b1}) $display("FAIL sub_zero: v=%b r=%h z=%b want 1 0 1", out_valid, result, zero); else pass_cnt++;
        consume();
        issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
        total_cnt++; if ({out_valid, result} !== {1'b1, 32'h1}) $display("FAIL slt_signed: v=%b r=%h want 1 00000001", out_valid, result); else pass_cnt++;
        consume();
        issue(4'b0011, 32'd1, 32'hFFFF_FFFF);
        total_cnt++; if ({result, zero} !== {32'h0, 1'b1}) $display("FAIL slt_false: r=%h z=%b want 0 1", result, zero); else pass_cnt++;
        consume();
        issue(4'b1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        total_cnt++; if (result !== 32'h1) $display("FAIL eq: r=%h want 00000001", result); else pass_cnt++;
        consume();
        issue(4'b1100, 32'hFFFF_FFFF, 32'd2);
        total_cnt++; if (result !== 32'h1) $display("FAIL add_wrap: r=%h want 00000001", result); else pass_cnt++;
        consume();
        issue(4'b1010, 32'h5, 32'h3);
        total_cnt++; if ({out_valid, result} !== {1'b1, 32'h0}) $display("FAIL undef_op: v=%b r=%h want 1 0", out_valid, result); else pass_cnt++;
        consume();
    endtask

    task automatic test_shifts();
        int cyc;
        issue(4'b0111, 32'h8000_0000, 32'd4);
        total_cnt++; if ({out_valid, busy} !== 2'b01) $display("FAIL sra_busy: valid,busy=%b want 01", {out_valid, busy}); else pass_cnt++;
        wait_valid(cyc);
        total_cnt++; if (cyc !== 5) $display("FAIL sra_latency: got %0d want 5", cyc); else pass_cnt++;
        total_cnt++; if (result !== 32'hF800_0000) $display("FAIL sra_result: got %h want f8000000", result); else pass_cnt++;
        step();
        total_cnt++; if ({out_valid, busy} !== 2'b11) $display("FAIL sra_hold: valid,busy=%b want 11", {out_valid, busy}); else pass_cnt++;
        consume();
        total_cnt++; if (busy !== 1'b0) $display("FAIL sra_release: busy=%b want 0", busy); else pass_cnt++;
        issue(4'b0101, 32'h8000_0000, 32'd4);
        wait_valid(cyc);
        total_cnt++; if ({cyc, result} !== {32'd5, 32'h0800_0000}) $display("FAIL srl: cyc=%0d r=%h want 5 08000000", cyc, result); else pass_cnt++;
        consume();
        issue(4'b0100, 32'h1234_5678, 32'hFFFF_FFE0);
        total_cnt++; if ({out_valid, result} !== {1'b1, 32'h1234_5678}) $display("FAIL sll_zero: v=%b r=%h want 1 12345678", out_valid, result); else pass_cnt++;
        consume();
    endtask

    task automatic test_back_to_back();
        issue(4'b1001, 32'hFF00, 32'h0FF0);
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if ({out_valid, result} !== {1'b1, 32'hF0F0}) $display("FAIL bp_hold%0d: v=%b r=%h want 1 0000f0f0", i, out_valid, result); else pass_cnt++;
            step();
        end
        out_ready = 1'b1;
        operation = 4'b0001; srcA = 32'hF0; srcB = 32'h0F; in_valid = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", in_ready); else pass_cnt++;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        total_cnt++; if ({out_valid, result} !== {1'b1, 32'hFF}) $display("FAIL b2b_result: v=%b r=%h want 1 000000ff", out_valid, result); else pass_cnt++;
        consume();
    endtask

    task automatic test_flush();
        int rose = 0;
        issue(4'b0100, 32'h1, 32'd20);
        for (int i = 0; i < 5; i++) begin
            if (out_valid) rose++;
            step();
        end
        flush = 1'b1;
        operation = 4'b0010; srcA = 32'd9; srcB = 32'd9; in_valid = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", in_ready); else pass_cnt++;
        step();
        flush = 1'b0; in_valid = 1'b0;
        if (out_valid) rose++;
        total_cnt++; if ({busy, rose} !== {1'b0, 32'd0}) $display("FAIL flush_idle: busy=%b rose=%0d want 0 0", busy, rose); else pass_cnt++;
        issue(4'b0010, 32'd3, 32'd4);
        total_cnt++; if ({out_valid, result} !== {1'b1, 32'd7}) $display("FAIL flush_next: v=%b r=%h want 1 00000007", out_valid, result); else pass_cnt++;
        consume();
        for (int i = 0; i < 25; i++) begin
            if (out_valid) rose++;
            step();
        end
        total_cnt++; if (rose !== 0) $display("FAIL flush_no_valid: rose=%0d want 0", rose); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        issue(4'b0111, 32'h8000_0000, 32'd10);
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({out_valid, busy, result} !== {2'b00, 32'h0}) $display("FAIL async_reset: v=%b b=%b r=%h want 0 0 0", out_valid, busy, result); else pass_cnt++;
        step();
        rst_n = 1'b1;
        issue(4'b0010, 32'd1, 32'd1);
        total_cnt++; if ({out_valid, result} !== {1'b1, 32'd2}) $display("FAIL post_reset_add: v=%b r=%h want 1 00000002", out_valid, result); else pass_cnt++;
        consume();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt_eq();
        test_shifts();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
